// File: rtl/keyboard_tracker.sv
// PS/2 device-to-host receiver with scan-code-set-2 decode for S, R, D, C, Enter, Space.
// Optional macro KBD_PARITY_CHECK_EN: frames failing odd parity are dropped.
module keyboard_tracker #(
  parameter int PULSE_OR_HOLD  = 0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  output logic s,
  output logic r,
  output logic d,
  output logic c,
  output logic enter,
  output logic space
);

  localparam int NKEYS = 6;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  // Key order matches the output concatenation below: s, r, d, c, enter, space.
  localparam logic [8*NKEYS-1:0] KEY_CODES = {8'h29, 8'h5A, 8'h21, 8'h23, 8'h2D, 8'h1B};

  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic ps2_dat_s1_q, ps2_dat_s2_q;
  logic fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_dat_s1_q   <= 1'b1;
      ps2_dat_s2_q   <= 1'b1;
    end else begin
      ps2_clk_s1_q   <= PS2_CLK;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_dat_s1_q   <= PS2_DAT;
      ps2_dat_s2_q   <= ps2_dat_s1_q;
    end
  end

  assign fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic [10:0]   frame;
  logic          frame_ok;

  // Bits 0..9 are shifted in LSB first; the stop bit is taken straight from the pin.
  assign frame = {ps2_dat_s2_q, shift_q};

`ifdef KBD_PARITY_CHECK_EN
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
`else
  assign frame_ok = ~frame[0] & frame[10] & (frame[9] | 1'b1);
`endif

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idle_d     = '0;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        shift_d   = '0;
        if (frame_ok) begin
          byte_vld_d = 1'b1;
          byte_d     = frame[8:1];
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {ps2_dat_s2_q, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        shift_d   = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      idle_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idle_q     <= idle_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
    end
  end

  logic [NKEYS-1:0] hit;
  logic [NKEYS-1:0] held_q, held_d;
  logic [NKEYS-1:0] pulse_q, pulse_d;
  logic             brk_q, brk_d, ext_q, ext_d;

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      assign hit[gi] = (byte_q == KEY_CODES[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    held_d  = held_q;
    pulse_d = '0;
    brk_d   = brk_q;
    ext_d   = ext_q;
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        // Extended codes (e.g. keypad Enter) never touch the tracked keys.
        if (!ext_q) begin
          if (brk_q) begin
            held_d = held_q & ~hit;
          end else begin
            pulse_d = hit & ~held_q;
            held_d  = held_q | hit;
          end
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_q  <= '0;
      pulse_q <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      held_q  <= held_d;
      pulse_q <= pulse_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
    end
  end

  logic [NKEYS-1:0] keys;
  assign keys = (PULSE_OR_HOLD != 0) ? held_q : pulse_q;
  assign {space, enter, c, d, r, s} = keys;

endmodule

// File: tb/tb_keyboard_tracker.sv
// Directed bench for keyboard_tracker: one pulse-mode and one hold-mode instance share the PS/2 lines.
module tb_keyboard_tracker;

  localparam int KS = 0, KR = 1, KD = 2, KC = 3, KEN = 4, KSP = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_drv = 1'b1;
  logic ps2_dat_drv = 1'b1;
  wire  ps2_clk_w;
  wire  ps2_dat_w;
  assign ps2_clk_w = ps2_clk_drv;
  assign ps2_dat_w = ps2_dat_drv;

  logic [5:0] out0, out1;

  keyboard_tracker #(.PULSE_OR_HOLD(0)) dut_pulse (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .s(out0[0]), .r(out0[1]), .d(out0[2]), .c(out0[3]), .enter(out0[4]), .space(out0[5])
  );

  keyboard_tracker #(.PULSE_OR_HOLD(1)) dut_hold (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .s(out1[0]), .r(out1[1]), .d(out1[2]), .c(out1[3]), .enter(out1[4]), .space(out1[5])
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int hi_cnt[6];
  int rise_cnt[6];
  int rise_cyc[6];
  logic [5:0] prev0 = '0;
  always @(negedge clock) begin
    for (int i = 0; i < 6; i++) begin
      if (out0[i]) begin
        hi_cnt[i]++;
        if (!prev0[i]) begin
          rise_cnt[i]++;
          rise_cyc[i] = cyc;
        end
      end
    end
    prev0 = out0;
  end

  int base_hi[6];
  int base_rise[6];
  int stop_cyc;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) begin
      base_hi[i]   = hi_cnt[i];
      base_rise[i] = rise_cnt[i];
    end
  endtask

  function automatic int dh(input int i);
    return hi_cnt[i] - base_hi[i];
  endfunction

  function automatic int dr(input int i);
    return rise_cnt[i] - base_rise[i];
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat_drv = f[i];
      tick(4);
      ps2_clk_drv = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(4);
      ps2_clk_drv = 1'b1;
    end
    tick(4);
    ps2_dat_drv = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), 11);
    tick(16);
  endtask

  int lat;

  initial begin
    tick(2);
    reset = 1'b0;
    tick(2);
    check("reset_pulse_outs", int'(out0), 0);
    check("reset_hold_outs", int'(out1), 0);

    // S make: single pulse with bounded latency, hold instance latches it
    snap();
    send_byte(8'h1B);
    lat = rise_cyc[KS] - stop_cyc;
    check("s_hi_cycles", dh(KS), 1);
    check("s_rises", dr(KS), 1);
    check("s_latency_le4", int'(lat >= 1 && lat <= 4), 1);
    check("others_quiet", dh(KR) + dh(KD) + dh(KC) + dh(KEN) + dh(KSP), 0);
    check("hold_s_set", int'(out1[KS]), 1);
    send_byte(8'hF0);
    send_byte(8'h1B);
    check("hold_s_released", int'(out1[KS]), 0);
    check("s_no_break_pulse", dh(KS), 1);

    // Enter typematic then release and re-press
    snap();
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'h5A);
    check("enter_typematic_hi", dh(KEN), 1);
    send_byte(8'hF0);
    send_byte(8'h5A);
    check("hold_enter_released", int'(out1[KEN]), 0);
    send_byte(8'h5A);
    check("enter_hi_cycles", dh(KEN), 2);
    check("enter_rises", dr(KEN), 2);
    send_byte(8'hF0);
    send_byte(8'h5A);

    // Space held across an untracked code
    snap();
    send_byte(8'h29);
    check("hold_space_set", int'(out1[KSP]), 1);
    send_byte(8'h1C);
    check("hold_space_kept", int'(out1[KSP]), 1);
    check("hold_untracked_quiet", int'(out1 & 6'b011111), 0);
    send_byte(8'hF0);
    check("hold_space_after_f0", int'(out1[KSP]), 1);
    send_byte(8'h29);
    check("hold_space_released", int'(out1[KSP]), 0);
    check("space_pulse_once", dh(KSP), 1);

    // Extended sequences ignored, flags clear afterwards
    snap();
    send_byte(8'hE0);
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    check("ext_enter_no_pulse", dh(KEN), 0);
    check("ext_enter_not_held", int'(out1[KEN]), 0);
    send_byte(8'h2D);
    check("r_after_ext", dh(KR), 1);
    check("hold_r_set", int'(out1[KR]), 1);

    // Timeout discards a partial frame
    snap();
    send_bits(make_frame(8'h23, 1'b0), 5);
    tick(60000);
    send_byte(8'h23);
    check("d_after_timeout", dh(KD), 1);

    // Reset mid-frame
    send_bits(make_frame(8'h21, 1'b0), 4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("midreset_pulse_outs", int'(out0), 0);
    check("midreset_hold_outs", int'(out1), 0);
    snap();
    send_byte(8'h21);
    check("c_after_reset", dh(KC), 1);
    check("hold_only_c", int'(out1), 8);

    // Wrong parity
    snap();
    send_bits(make_frame(8'h1B, 1'b1), 11);
    tick(16);
`ifdef KBD_PARITY_CHECK_EN
    check("bad_parity_s", dh(KS), 0);
`else
    check("bad_parity_s", dh(KS), 1);
`endif
    send_byte(8'hF0);
    send_byte(8'h1B);
    send_byte(8'h1B);
`ifdef KBD_PARITY_CHECK_EN
    check("good_parity_s", dh(KS), 1);
`else
    check("good_parity_s", dh(KS), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
